fetch_stage: RTL and testbench

Instruction-fetch stage of the 5-stage MIPS pipeline. Holds the PC, drives the instruction-memory address, and computes the next PC from sequential flow or an ID-stage redirect (branch/jump). Owns the IF/ID pipeline register. Sits directly upstream of the stall control unit and obeys its `PC_WriteEn` / `IFID_WriteEn` outputs. Also keeps a saturating count of load-use stall cycles for performance monitoring.

---
 rtl/fetch_stage.sv | 76 +++++++
 tb/tb_fetch_stage.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - MIPS instruction-fetch stage: PC, next-PC selection, IF/ID register, stall counter
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             PC_WriteEn,
  input  logic             IFID_WriteEn,
  input  logic             ID_BranchTaken,
  input  logic [31:0]      ID_BranchTarget,
  input  logic             ID_Jump,
  input  logic [31:0]      ID_JumpTarget,
  output logic [31:0]      IM_Addr,
  input  logic [31:0]      IM_Instr,
  output logic [31:0]      IFID_PC4,
  output logic [31:0]      IFID_Instr,
  output logic             IFID_Valid,
  output logic [CNT_W-1:0] StallCount
);

  logic [31:0]      r_pc;
  logic [31:0]      r_ifid_pc4;
  logic [31:0]      r_ifid_instr;
  logic             r_ifid_valid;
  logic [CNT_W-1:0] r_stall_cnt;

  logic [31:0]      w_pc4;
  logic             w_redir;
  logic [31:0]      w_target;
  logic             w_stall;
  logic             w_cnt_sat;

  assign w_pc4     = r_pc + 32'd4;
  // Redirects are only honoured when the PC may move; a stalled branch re-resolves next cycle.
  assign w_redir   = PC_WriteEn & (ID_BranchTaken | ID_Jump);
  assign w_target  = ID_BranchTaken ? {ID_BranchTarget[31:2], 2'b00}
                                    : {ID_JumpTarget[31:2], 2'b00};
  assign w_stall   = ~PC_WriteEn & ~IFID_WriteEn;
  assign w_cnt_sat = &r_stall_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc <= RESET_PC;
    end else if (PC_WriteEn) begin
      r_pc <= w_redir ? w_target : w_pc4;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || w_redir) begin
      r_ifid_instr <= 32'd0;
      r_ifid_pc4   <= 32'd0;
      r_ifid_valid <= 1'b0;
    end else if (IFID_WriteEn) begin
      r_ifid_instr <= IM_Instr;
      r_ifid_pc4   <= w_pc4;
      r_ifid_valid <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cnt <= '0;
    end else if (w_stall && !w_cnt_sat) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign IM_Addr    = r_pc;
  assign IFID_PC4   = r_ifid_pc4;
  assign IFID_Instr = r_ifid_instr;
  assign IFID_Valid = r_ifid_valid;
  assign StallCount = r_stall_cnt;

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed table plus randomized reference-model check of fetch_stage
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset, pwe, iwe, bt, jmp;
  logic [31:0] btgt, jtgt;

  logic [31:0] im_addr, im_instr, ifid_pc4, ifid_instr;
  logic        ifid_valid;
  logic [15:0] stall_cnt;

  logic [31:0] im_addr2, im_instr2, ifid_pc4_2, ifid_instr2;
  logic        ifid_valid2;
  logic [1:0]  stall_cnt2;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // Memory returns the word address as the instruction word.
  assign im_instr  = im_addr >> 2;
  assign im_instr2 = im_addr2 >> 2;

  fetch_stage u_dut (
    .clk(clk), .reset(reset), .PC_WriteEn(pwe), .IFID_WriteEn(iwe),
    .ID_BranchTaken(bt), .ID_BranchTarget(btgt), .ID_Jump(jmp), .ID_JumpTarget(jtgt),
    .IM_Addr(im_addr), .IM_Instr(im_instr), .IFID_PC4(ifid_pc4), .IFID_Instr(ifid_instr),
    .IFID_Valid(ifid_valid), .StallCount(stall_cnt)
  );

  fetch_stage #(.RESET_PC(32'h0000_0000), .CNT_W(2)) u_dut2 (
    .clk(clk), .reset(reset), .PC_WriteEn(pwe), .IFID_WriteEn(iwe),
    .ID_BranchTaken(bt), .ID_BranchTarget(btgt), .ID_Jump(jmp), .ID_JumpTarget(jtgt),
    .IM_Addr(im_addr2), .IM_Instr(im_instr2), .IFID_PC4(ifid_pc4_2), .IFID_Instr(ifid_instr2),
    .IFID_Valid(ifid_valid2), .StallCount(stall_cnt2)
  );

  typedef struct {
    logic        rst, pwe, iwe, bt, j;
    logic [31:0] btgt, jtgt;
    logic [31:0] e_pc, e_instr, e_pc4;
    logic        e_valid;
    int          e_cnt, e_cnt2;
  } vec_t;

  vec_t tbl[21];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input logic [31:0] pc, input logic [31:0] ins,
                           input logic [31:0] p4, input logic v, input int c, input int c2);
    chk({tag, " IM_Addr"},     im_addr,               pc);
    chk({tag, " IFID_Instr"},  ifid_instr,            ins);
    chk({tag, " IFID_PC4"},    ifid_pc4,              p4);
    chk({tag, " IFID_Valid"},  {31'd0, ifid_valid},   {31'd0, v});
    chk({tag, " StallCount"},  {16'd0, stall_cnt},    c);
    chk({tag, " IM_Addr2"},    im_addr2,              pc);
    chk({tag, " IFID_Instr2"}, ifid_instr2,           ins);
    chk({tag, " IFID_PC4_2"},  ifid_pc4_2,            p4);
    chk({tag, " IFID_Valid2"}, {31'd0, ifid_valid2},  {31'd0, v});
    chk({tag, " StallCount2"}, {30'd0, stall_cnt2},   c2);
  endtask

  function automatic vec_t mk(logic r, logic p, logic i, logic b, logic [31:0] bg, logic j,
                              logic [31:0] jg, logic [31:0] epc, logic [31:0] ei,
                              logic [31:0] ep4, logic ev, int ec, int ec2);
    vec_t v;
    v.rst = r; v.pwe = p; v.iwe = i; v.bt = b; v.btgt = bg; v.j = j; v.jtgt = jg;
    v.e_pc = epc; v.e_instr = ei; v.e_pc4 = ep4; v.e_valid = ev; v.e_cnt = ec; v.e_cnt2 = ec2;
    return v;
  endfunction

  // Reference model state
  logic [31:0] m_pc, m_instr, m_pc4;
  logic        m_valid;
  int          m_cnt, m_cnt2;

  task automatic model_step();
    logic [31:0] tgt;
    logic        redir;
    if (reset) begin
      m_pc = 0; m_instr = 0; m_pc4 = 0; m_valid = 0; m_cnt = 0; m_cnt2 = 0;
    end else begin
      redir = pwe && (bt || jmp);
      tgt   = (bt ? btgt : jtgt) & ~32'd3;
      if (redir) begin
        m_instr = 0; m_pc4 = 0; m_valid = 0;
      end else if (iwe) begin
        m_instr = m_pc / 4; m_pc4 = m_pc + 4; m_valid = 1;
      end
      if (!pwe && !iwe) begin
        if (m_cnt < 65535) m_cnt++;
        if (m_cnt2 < 3) m_cnt2++;
      end
      if (pwe) m_pc = redir ? tgt : m_pc + 4;
    end
  endtask

  initial begin
    reset = 1; pwe = 1; iwe = 1; bt = 0; jmp = 0; btgt = 0; jtgt = 0;

    //            rst p i bt btgt          j jtgt          pc            instr          pc4           v  c  c2
    tbl[0]  = mk(1, 1, 1, 0, 0,            0, 0,           32'h0,        32'h0,         32'h0,        0, 0, 0);
    tbl[1]  = mk(0, 1, 1, 0, 0,            0, 0,           32'h4,        32'h0,         32'h4,        1, 0, 0);
    tbl[2]  = mk(0, 1, 1, 0, 0,            0, 0,           32'h8,        32'h1,         32'h8,        1, 0, 0);
    tbl[3]  = mk(0, 0, 0, 0, 0,            0, 0,           32'h8,        32'h1,         32'h8,        1, 1, 1);
    tbl[4]  = mk(0, 1, 1, 0, 0,            0, 0,           32'hC,        32'h2,         32'hC,        1, 1, 1);
    tbl[5]  = mk(0, 1, 1, 0, 0,            0, 0,           32'h10,       32'h3,         32'h10,       1, 1, 1);
    tbl[6]  = mk(0, 1, 1, 1, 32'h103,      0, 0,           32'h100,      32'h0,         32'h0,        0, 1, 1);
    tbl[7]  = mk(0, 1, 1, 0, 0,            0, 0,           32'h104,      32'h40,        32'h104,      1, 1, 1);
    tbl[8]  = mk(0, 0, 0, 1, 32'h200,      0, 0,           32'h104,      32'h40,        32'h104,      1, 2, 2);
    tbl[9]  = mk(0, 1, 1, 1, 32'h200,      1, 32'h300,     32'h200,      32'h0,         32'h0,        0, 2, 2);
    tbl[10] = mk(0, 1, 1, 0, 0,            1, 32'hFFFFFFFF, 32'hFFFFFFFC, 32'h0,        32'h0,        0, 2, 2);
    tbl[11] = mk(0, 1, 1, 0, 0,            0, 0,           32'h0,        32'h3FFFFFFF,  32'h0,        1, 2, 2);
    tbl[12] = mk(0, 1, 0, 0, 0,            0, 0,           32'h4,        32'h3FFFFFFF,  32'h0,        1, 2, 2);
    tbl[13] = mk(0, 0, 1, 0, 0,            0, 0,           32'h4,        32'h1,         32'h8,        1, 2, 2);
    tbl[14] = mk(1, 1, 1, 0, 0,            0, 0,           32'h0,        32'h0,         32'h0,        0, 0, 0);
    tbl[15] = mk(0, 0, 0, 0, 0,            0, 0,           32'h0,        32'h0,         32'h0,        0, 1, 1);
    tbl[16] = mk(0, 0, 0, 0, 0,            0, 0,           32'h0,        32'h0,         32'h0,        0, 2, 2);
    tbl[17] = mk(0, 0, 0, 0, 0,            0, 0,           32'h0,        32'h0,         32'h0,        0, 3, 3);
    tbl[18] = mk(0, 0, 0, 0, 0,            0, 0,           32'h0,        32'h0,         32'h0,        0, 4, 3);
    tbl[19] = mk(0, 0, 0, 0, 0,            0, 0,           32'h0,        32'h0,         32'h0,        0, 5, 3);
    tbl[20] = mk(1, 0, 0, 1, 32'h500,      1, 32'h600,     32'h0,        32'h0,         32'h0,        0, 0, 0);

    for (int k = 0; k < 21; k++) begin
      reset = tbl[k].rst; pwe = tbl[k].pwe; iwe = tbl[k].iwe;
      bt = tbl[k].bt; btgt = tbl[k].btgt; jmp = tbl[k].j; jtgt = tbl[k].jtgt;
      @(posedge clk);
      @(negedge clk);
      check_all($sformatf("row%0d", k), tbl[k].e_pc, tbl[k].e_instr, tbl[k].e_pc4,
                tbl[k].e_valid, tbl[k].e_cnt, tbl[k].e_cnt2);
    end

    // Randomized phase against the reference model
    reset = 1; pwe = 1; iwe = 1; bt = 0; jmp = 0;
    model_step();
    @(posedge clk);
    @(negedge clk);
    check_all("rnd_reset", m_pc, m_instr, m_pc4, m_valid, m_cnt, m_cnt2);

    for (int k = 0; k < 400; k++) begin
      reset = ($urandom_range(0, 59) == 0);
      case ($urandom_range(0, 7))
        0:       begin pwe = 0; iwe = 0; end
        1:       begin pwe = 1; iwe = 0; end
        2:       begin pwe = 0; iwe = 1; end
        default: begin pwe = 1; iwe = 1; end
      endcase
      bt   = ($urandom_range(0, 5) == 0);
      jmp  = ($urandom_range(0, 7) == 0);
      btgt = $urandom();
      jtgt = $urandom();
      model_step();
      @(posedge clk);
      @(negedge clk);
      check_all($sformatf("rnd%0d", k), m_pc, m_instr, m_pc4, m_valid, m_cnt, m_cnt2);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
